// File: rtl/ff_bank_pkg.sv
// Shared constants for the universal flip-flop bank: mode encodings and
// the S=R=1 resolution policies used in SR mode.
package ff_bank_pkg;

  localparam logic [1:0] MODE_SR = 2'b00;
  localparam logic [1:0] MODE_JK = 2'b01;
  localparam logic [1:0] MODE_D  = 2'b10;
  localparam logic [1:0] MODE_T  = 2'b11;

  localparam int POL_HOLD = 0;
  localparam int POL_SET  = 1;
  localparam int POL_RST  = 2;

  // Next state of one SR bit when both S and R are asserted.
  function automatic logic sr_both_next(input int policy, input logic q_cur);
    logic res;
    res = q_cur;
    if (policy == POL_SET) begin
      res = 1'b1;
    end else if (policy == POL_RST) begin
      res = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/ff_cell.sv
// One channel of the bank: SR/JK/D/T next-state logic, the state register
// and a combinational flag for an S=R=1 input in SR mode.
module ff_cell
  import ff_bank_pkg::*;
#(
  parameter int SR_POLICY = POL_HOLD,
  parameter bit RESET_Q   = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] mode,
  input  logic       a,
  input  logic       b,
  output logic       q,
  output logic       illegal
);

  logic q_q;
  logic q_d;

  // Next-state selection for the current mode; B is only looked at in SR/JK.
  always_comb begin
    q_d = q_q;
    case (mode)
      MODE_SR: begin
        case ({a, b})
          2'b10:   q_d = 1'b1;
          2'b01:   q_d = 1'b0;
          2'b11:   q_d = sr_both_next(SR_POLICY, q_q);
          default: q_d = q_q;
        endcase
      end
      MODE_JK: begin
        case ({a, b})
          2'b10:   q_d = 1'b1;
          2'b01:   q_d = 1'b0;
          2'b11:   q_d = ~q_q;
          default: q_d = q_q;
        endcase
      end
      MODE_D:  q_d = a;
      MODE_T:  q_d = a ? ~q_q : q_q;
      default: q_d = q_q;
    endcase
  end

  // State register: synchronous active-low reset beats the clock enable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q <= RESET_Q;
    end else if (en) begin
      q_q <= q_d;
    end
  end

  assign q       = q_q;
  // Enable gating is applied at the bank, so this is purely input-based.
  assign illegal = (mode == MODE_SR) && a && b;

endmodule

// File: rtl/universal_ff_bank.sv
// Bank of WIDTH independent flip-flops sharing one mode and enable, with a
// sticky error flag and a saturating counter of illegal SR input cycles.
module universal_ff_bank
  import ff_bank_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CNT_W     = 4,
  parameter int SR_POLICY = POL_HOLD,
  parameter bit RESET_Q   = 1'b0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             ERR_CLR,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QBAR,
  output logic             ERR,
  output logic [CNT_W-1:0] ERR_CNT
);

  logic [WIDTH-1:0] illegal_vec;
  logic             illegal_cycle;
  logic             err_q;
  logic             err_d;
  logic [CNT_W-1:0] err_cnt_q;
  logic [CNT_W-1:0] err_cnt_d;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cell
      ff_cell #(
        .SR_POLICY(SR_POLICY),
        .RESET_Q  (RESET_Q)
      ) u_cell (
        .clk    (CLK),
        .rst_n  (RST_N),
        .en     (EN),
        .mode   (MODE),
        .a      (A[gi]),
        .b      (B[gi]),
        .q      (Q[gi]),
        .illegal(illegal_vec[gi])
      );
    end
  endgenerate

  // One event per cycle no matter how many bits are illegal.
  assign illegal_cycle = EN && (|illegal_vec);

  // Error bookkeeping: a new illegal event wins over a simultaneous clear.
  always_comb begin
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    if (illegal_cycle) begin
      err_d = 1'b1;
      if (ERR_CLR) begin
        err_cnt_d = CNT_W'(1);
      end else if (!(&err_cnt_q)) begin
        err_cnt_d = err_cnt_q + CNT_W'(1);
      end
    end else if (ERR_CLR) begin
      err_d     = 1'b0;
      err_cnt_d = '0;
    end
  end

  // Error registers; reset discards any event seen in the same cycle.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign QBAR    = ~Q;
  assign ERR     = err_q;
  assign ERR_CNT = err_cnt_q;

endmodule

// File: tb/tb_universal_ff_bank.sv
// Scoreboard bench for universal_ff_bank: two instances (set-dominant with
// reset value 1, reset-dominant with reset value 0) see identical stimulus.
module tb_universal_ff_bank;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       EN;
  logic [1:0] MODE;
  logic [7:0] A;
  logic [7:0] B;
  logic       ERR_CLR;

  logic [7:0] q_s, qbar_s, q_r, qbar_r;
  logic       err_s, err_r;
  logic [3:0] cnt_s, cnt_r;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      name;
    logic [7:0] qs;
    logic [7:0] qr;
    logic       err;
    logic [3:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  always #5 CLK = ~CLK;

  universal_ff_bank #(.WIDTH(8), .CNT_W(4), .SR_POLICY(1), .RESET_Q(1'b1)) dut_s (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .MODE(MODE), .A(A), .B(B),
    .ERR_CLR(ERR_CLR), .Q(q_s), .QBAR(qbar_s), .ERR(err_s), .ERR_CNT(cnt_s)
  );

  universal_ff_bank #(.WIDTH(8), .CNT_W(4), .SR_POLICY(2), .RESET_Q(1'b0)) dut_r (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .MODE(MODE), .A(A), .B(B),
    .ERR_CLR(ERR_CLR), .Q(q_r), .QBAR(qbar_r), .ERR(err_r), .ERR_CNT(cnt_r)
  );

  task automatic cmp(input string txn, input string what,
                     input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s actual=%h required=%h", txn, what, act, req);
    end
  endtask

  // Monitor: every clock edge produces one output state; check it mid-cycle.
  always @(negedge CLK) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cmp(e.name, "q_set", q_s, e.qs);
      cmp(e.name, "qbar_set", qbar_s, ~e.qs);
      cmp(e.name, "q_rst", q_r, e.qr);
      cmp(e.name, "qbar_rst", qbar_r, ~e.qr);
      cmp(e.name, "err_set", {7'd0, err_s}, {7'd0, e.err});
      cmp(e.name, "err_rst", {7'd0, err_r}, {7'd0, e.err});
      cmp(e.name, "cnt_set", {4'd0, cnt_s}, {4'd0, e.cnt});
      cmp(e.name, "cnt_rst", {4'd0, cnt_r}, {4'd0, e.cnt});
      $display("txn %-14s q_set=%h q_rst=%h err=%0d cnt=%0d", e.name, q_s, q_r, err_s, cnt_s);
    end
  end

  // Apply one cycle of inputs and queue the hand-computed result of that edge.
  task automatic step(input string name, input logic rst_n, input logic en,
                      input logic [1:0] mode, input logic [7:0] a, input logic [7:0] b,
                      input logic clr, input logic [7:0] qs, input logic [7:0] qr,
                      input logic err, input logic [3:0] cnt);
    exp_t e;
    RST_N = rst_n; EN = en; MODE = mode; A = a; B = b; ERR_CLR = clr;
    @(posedge CLK);
    e.name = name; e.qs = qs; e.qr = qr; e.err = err; e.cnt = cnt;
    exp_q.push_back(e);
    #1;
  endtask

  localparam logic [1:0] M_SR = 2'b00, M_JK = 2'b01, M_D = 2'b10, M_T = 2'b11;

  initial begin
    int budget;
    RST_N = 1'b0; EN = 1'b1; MODE = M_SR; A = 8'hFF; B = 8'hFF; ERR_CLR = 1'b0;

    //   name            rst en mode  A      B      clr  q_set  q_rst  err cnt
    step("reset",        0, 1, M_SR, 8'hFF, 8'hFF, 0, 8'hFF, 8'h00, 0, 4'd0);
    step("d_zero",       1, 1, M_D,  8'h00, 8'hFF, 0, 8'h00, 8'h00, 0, 4'd0);
    step("sr_policy",    1, 1, M_SR, 8'h0F, 8'h03, 0, 8'h0F, 8'h0C, 1, 4'd1);
    step("sr_hold",      1, 1, M_SR, 8'h00, 8'h00, 0, 8'h0F, 8'h0C, 1, 4'd1);
    step("d_a5",         1, 1, M_D,  8'hA5, 8'h00, 0, 8'hA5, 8'hA5, 1, 4'd1);
    step("t_toggle",     1, 1, M_T,  8'hFF, 8'h00, 0, 8'h5A, 8'h5A, 1, 4'd1);
    step("jk_toggle",    1, 1, M_JK, 8'hF0, 8'hF0, 0, 8'hAA, 8'hAA, 1, 4'd1);
    step("jk_setrst",    1, 1, M_JK, 8'h0F, 8'hF0, 0, 8'h0F, 8'h0F, 1, 4'd1);
    step("d_3c",         1, 1, M_D,  8'h3C, 8'h00, 0, 8'h3C, 8'h3C, 1, 4'd1);
    step("en0_t",        1, 0, M_T,  8'hFF, 8'h00, 0, 8'h3C, 8'h3C, 1, 4'd1);
    step("en0_sr_ill",   1, 0, M_SR, 8'hFF, 8'hFF, 0, 8'h3C, 8'h3C, 1, 4'd1);
    step("en0_d",        1, 0, M_D,  8'hC3, 8'h00, 0, 8'h3C, 8'h3C, 1, 4'd1);
    step("en0_jk",       1, 0, M_JK, 8'hFF, 8'hFF, 0, 8'h3C, 8'h3C, 1, 4'd1);
    step("err_clr",      1, 1, M_D,  8'h3C, 8'h00, 1, 8'h3C, 8'h3C, 0, 4'd0);
    for (int i = 0; i < 20; i++) begin
      step($sformatf("sat_%0d", i), 1, 1, M_SR, 8'h01, 8'h01, 0, 8'h3D, 8'h3C, 1,
           (i + 1 > 15) ? 4'd15 : 4'(i + 1));
    end
    step("clr_vs_ill",   1, 1, M_SR, 8'h01, 8'h01, 1, 8'h3D, 8'h3C, 1, 4'd1);
    step("t_no_ill",     1, 1, M_T,  8'hFF, 8'hFF, 0, 8'hC2, 8'hC3, 1, 4'd1);
    step("clr_en0",      1, 0, M_SR, 8'hFF, 8'hFF, 1, 8'hC2, 8'hC3, 0, 4'd0);
    step("sr_all_ill",   1, 1, M_SR, 8'hFF, 8'hFF, 0, 8'hFF, 8'h00, 1, 4'd1);
    step("mid_reset",    0, 1, M_SR, 8'hFF, 8'hFF, 0, 8'hFF, 8'h00, 0, 4'd0);
    step("post_reset",   1, 1, M_D,  8'h81, 8'h00, 0, 8'h81, 8'h81, 0, 4'd0);
    step("sr_legal",     1, 1, M_SR, 8'hF0, 8'h0F, 0, 8'hF0, 8'hF0, 0, 4'd0);

    EN = 1'b0;
    budget = 0;
    while (exp_q.size() > 0 && budget < 10) begin
      @(posedge CLK);
      budget++;
    end
    if (exp_q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/universal_ff_bank.md
UNIVERSAL_FF_BANK -- requirements
Module: universal_ff_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning number of independent flip-flop channels (1..64).
REQ-002 SHALL have parameter CNT_W, default 4, meaning width of the illegal-input event counter.
REQ-003 SHALL have parameter SR_POLICY, default 0, meaning the SR-mode S=R=1 policy: 0 hold, 1 set-dominant, 2 reset-dominant.
REQ-004 SHALL have parameter RESET_Q, default 0, meaning the reset value of every Q bit (0 or 1).
REQ-005 SHALL have port CLK  input  1  system clock, rising-edge active.
REQ-006 SHALL have port RST_N  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port EN  input  1  clock enable; state updates only when high.
REQ-008 SHALL have port MODE  input  2  operating mode: 00 SR, 01 JK, 10 D, 11 T.
REQ-009 SHALL have port A  input  WIDTH  per-channel S/J/D/T input.
REQ-010 SHALL have port B  input  WIDTH  per-channel R/K input, ignored in D and T modes.
REQ-011 SHALL have port ERR_CLR  input  1  clears ERR and ERR_CNT.
REQ-012 SHALL have port Q  output  WIDTH  registered state.
REQ-013 SHALL have port QBAR  output  WIDTH  complement of Q.
REQ-014 SHALL have port ERR  output  1  sticky illegal-input flag.
REQ-015 SHALL have port ERR_CNT  output  CNT_W  saturating count of illegal-input cycles.
REQ-016 SHALL use one clock, CLK; reset RST_N is synchronous and active-low.

Function
REQ-017 SHALL update Q on the rising CLK edge when RST_N=1 and EN=1; latency one cycle from input sampling to Q.
REQ-018 SHALL hold Q, ERR and ERR_CNT unchanged when EN=0, except that ERR_CLR still clears them.
REQ-019 SR mode, per bit: A=1,B=0 -> 1; A=0,B=1 -> 0; A=0,B=0 -> hold; A=1,B=1 -> per SR_POLICY.
REQ-020 JK mode, per bit: as SR for 10/01/00; A=1,B=1 -> toggle.
REQ-021 D mode, per bit: Q <= A.
REQ-022 T mode, per bit: A=1 -> toggle; A=0 -> hold.
REQ-023 SHALL apply MODE as sampled in the same edge; a mode change needs no idle cycle.
REQ-024 SHALL drive QBAR = ~Q combinationally at all times, including during reset.
REQ-025 Illegal cycle = EN=1, MODE=SR, and at least one bit with A=B=1; JK/D/T modes never raise illegal.
REQ-026 SHALL set ERR on an illegal cycle; ERR stays high until ERR_CLR or reset.
REQ-027 SHALL increment ERR_CNT by exactly 1 per illegal cycle, regardless of how many bits are illegal; saturate at all-ones, no wrap.
REQ-028 ERR_CLR=1 on a non-illegal cycle -> ERR=0, ERR_CNT=0 at the next edge.
REQ-029 ERR_CLR=1 on an illegal cycle -> ERR=1, ERR_CNT=1 (the new event wins over the clear).

Reset
REQ-030 When RST_N=0 at a rising edge: Q = {WIDTH{RESET_Q}}, ERR=0, ERR_CNT=0.
REQ-031 Reset SHALL take priority over EN, MODE, A/B and ERR_CLR; an illegal input during reset is not counted.
REQ-032 Asserting reset mid-operation SHALL discard all state at that edge; the first update after release uses inputs from the first cycle with RST_N=1.

Structure
REQ-033 Package ff_bank_pkg SHALL hold the MODE encoding constants (MODE_SR, MODE_JK, MODE_D, MODE_T) and the SR_POLICY constants (POL_HOLD, POL_SET, POL_RST).
REQ-034 Sub-module ff_cell SHALL implement one channel's next-state logic and register, plus its illegal flag; universal_ff_bank instantiates it WIDTH times.
REQ-035 The bank level SHALL OR-reduce the per-cell illegal flags and own ERR and ERR_CNT.

Verification
REQ-036 Reset: RST_N=0 with RESET_Q=1, WIDTH=8 -> Q=8'hFF, QBAR=8'h00, ERR=0, ERR_CNT=0 after one edge.
REQ-037 SR policy: SR_POLICY=1, Q=8'h00, A=8'h0F, B=8'h03 -> Q=8'h0F, ERR=1, ERR_CNT=1; SR_POLICY=2, same stimulus -> Q=8'h0C.
REQ-038 Modes: Q=8'hA5 in T mode, A=8'hFF -> Q=8'h5A; JK mode, A=B=8'hF0 -> Q=8'hAA; D mode, A=8'h3C -> Q=8'h3C.
REQ-039 Saturation: CNT_W=4, 20 consecutive illegal cycles -> ERR_CNT=4'hF with no wrap; then ERR_CLR on an illegal cycle -> ERR_CNT=1, ERR=1.
REQ-040 Enable/reset: EN=0 with toggling inputs -> Q is stable; RST_N=0 asserted mid-sequence with A=B=8'hFF in SR mode -> Q=RESET_Q and ERR_CNT=0.
